// File: rtl/g729_basic_op_pkg.sv
// +---------------------------------------------------------------------------+
// | g729_basic_op_pkg : opcodes and saturation limits for the basic-op port.  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

package g729_basic_op_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_L_MULT = 3'd0;
  localparam op_t OP_MULT   = 3'd1;
  localparam op_t OP_L_MAC  = 3'd2;
  localparam op_t OP_L_MSU  = 3'd3;
  localparam op_t OP_ADD    = 3'd4;
  localparam op_t OP_L_SHR  = 3'd5;
  localparam op_t OP_L_ADD  = 3'd6;
  localparam op_t OP_RSVD   = 3'd7;

  localparam logic [31:0] MAX_32 = 32'h7FFF_FFFF;
  localparam logic [31:0] MIN_32 = 32'h8000_0000;
  localparam logic [15:0] MAX_16 = 16'h7FFF;
  localparam logic [15:0] MIN_16 = 16'h8000;

endpackage

`default_nettype wire

// File: rtl/basic_op_sat.sv
// +---------------------------------------------------------------------------+
// | basic_op_sat : clamps a 34-bit two's-complement value to 32 or 16 bits.   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module basic_op_sat
  import g729_basic_op_pkg::*;
#(
  parameter bit NARROW = 1'b0
) (
  input  logic [33:0] i_val,
  output logic [31:0] o_res,
  output logic        o_ovf
);

  generate
    if (NARROW) begin : g_sat16
      // 16-bit result is returned sign-extended to 32 bits
      always_comb begin
        o_ovf = (i_val[33:15] != {19{1'b0}}) && (i_val[33:15] != {19{1'b1}});
        if (o_ovf) begin
          o_res = i_val[33] ? {16'hFFFF, MIN_16} : {16'h0000, MAX_16};
        end else begin
          o_res = {{16{i_val[15]}}, i_val[15:0]};
        end
      end
    end else begin : g_sat32
      always_comb begin
        o_ovf = (i_val[33:31] != 3'b000) && (i_val[33:31] != 3'b111);
        if (o_ovf) begin
          o_res = i_val[33] ? MIN_32 : MAX_32;
        end else begin
          o_res = i_val[31:0];
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/basic_op_responder.sv
// +---------------------------------------------------------------------------+
// | basic_op_responder : two-stage G.729 basic-op pipeline, valid/ready + tag.|
// | Optional BASIC_OP_OVF_STICKY_EN adds ovfSticky/ovfClear.  Rev 1.0         |
// +---------------------------------------------------------------------------+
`default_nettype none

module basic_op_responder
  import g729_basic_op_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic [2:0]       reqOp,
  input  logic [15:0]      reqA,
  input  logic [15:0]      reqB,
  input  logic [31:0]      reqC,
  input  logic [TAG_W-1:0] reqTag,
  output logic             rspValid,
  input  logic             rspReady,
  output logic [31:0]      rspData,
  output logic             rspOvf,
  output logic [TAG_W-1:0] rspTag
`ifdef BASIC_OP_OVF_STICKY_EN
  ,
  output logic             ovfSticky,
  input  logic             ovfClear
`endif
);

  // Stage registers
  logic               ready_en_q, ready_en_d;
  logic               s1_valid_q, s1_valid_d;
  op_t                s1_op_q,    s1_op_d;
  logic [15:0]        s1_a_q,     s1_a_d;
  logic [15:0]        s1_b_q,     s1_b_d;
  logic [31:0]        s1_c_q,     s1_c_d;
  logic signed [32:0] s1_p_q,     s1_p_d;
  logic [TAG_W-1:0]   s1_tag_q,   s1_tag_d;
  logic               s2_valid_q, s2_valid_d;
  logic [31:0]        s2_data_q,  s2_data_d;
  logic               s2_ovf_q,   s2_ovf_d;
  logic [TAG_W-1:0]   s2_tag_q,   s2_tag_d;
`ifdef BASIC_OP_OVF_STICKY_EN
  logic               sticky_q,   sticky_d;
`endif

  logic               w_advance;
  logic               w_req_fire;
  logic signed [31:0] w_prod32;

  // Stage-2 datapath
  logic [33:0]        w_lm34;
  logic [31:0]        w_lm_sat;
  logic               w_lm_ovf;
  logic signed [33:0] w_p34;
  logic [33:0]        w_narrow34;
  logic [31:0]        w_narrow_res;
  logic               w_narrow_ovf;
  logic [33:0]        w_c34;
  logic [33:0]        w_wide34;
  logic [31:0]        w_wide_res;
  logic               w_wide_ovf;
  logic [16:0]        w_neg_b;
  logic [4:0]         w_shamt;
  logic [31:0]        w_shl;
  logic [31:0]        w_shl_back;
  logic [31:0]        w_shift_res;
  logic               w_shift_ovf;
  logic [31:0]        w_res;
  logic               w_res_ovf;

  // A stalled result blocks the whole pipe, so s1 never overruns s2
  assign w_advance  = !s2_valid_q || rspReady;
  assign reqReady   = ready_en_q && w_advance;
  assign w_req_fire = reqValid && reqReady;
  assign w_prod32   = $signed(reqA) * $signed(reqB);

  assign rspValid = s2_valid_q;
  assign rspData  = s2_data_q;
  assign rspOvf   = s2_ovf_q;
  assign rspTag   = s2_tag_q;
`ifdef BASIC_OP_OVF_STICKY_EN
  assign ovfSticky = sticky_q;
`endif

  assign w_lm34 = {s1_p_q, 1'b0};
  assign w_p34  = $signed({s1_p_q[32], s1_p_q});
  assign w_c34  = {{2{s1_c_q[31]}}, s1_c_q};

  basic_op_sat #(.NARROW(1'b0)) u_sat_lm (
    .i_val (w_lm34),
    .o_res (w_lm_sat),
    .o_ovf (w_lm_ovf)
  );

  basic_op_sat #(.NARROW(1'b0)) u_sat_wide (
    .i_val (w_wide34),
    .o_res (w_wide_res),
    .o_ovf (w_wide_ovf)
  );

  basic_op_sat #(.NARROW(1'b1)) u_sat_narrow (
    .i_val (w_narrow34),
    .o_res (w_narrow_res),
    .o_ovf (w_narrow_ovf)
  );

  always_comb begin
    w_narrow34 = {{18{s1_a_q[15]}}, s1_a_q} + {{18{s1_b_q[15]}}, s1_b_q};
    if (s1_op_q == OP_MULT) begin
      w_narrow34 = w_p34 >>> 15;
    end
    case (s1_op_q)
      OP_L_MAC: w_wide34 = w_c34 + {{2{w_lm_sat[31]}}, w_lm_sat};
      OP_L_MSU: w_wide34 = w_c34 - {{2{w_lm_sat[31]}}, w_lm_sat};
      default:  w_wide34 = w_c34 + {{2{s1_a_q[15]}}, s1_a_q, s1_b_q};
    endcase
  end

  // Negative shift counts become a saturating left shift
  always_comb begin
    w_neg_b     = 17'd0 - {s1_b_q[15], s1_b_q};
    w_shamt     = 5'd0;
    w_shl       = 32'd0;
    w_shl_back  = 32'd0;
    w_shift_ovf = 1'b0;
    if (!s1_b_q[15]) begin
      w_shamt     = (s1_b_q > 16'd31) ? 5'd31 : s1_b_q[4:0];
      w_shift_res = $signed(s1_c_q) >>> w_shamt;
    end else begin
      w_shamt     = (w_neg_b > 17'd31) ? 5'd31 : w_neg_b[4:0];
      w_shl       = s1_c_q << w_shamt;
      w_shl_back  = $signed(w_shl) >>> w_shamt;
      w_shift_ovf = (w_shl_back != s1_c_q);
      if (w_shift_ovf) begin
        w_shift_res = s1_c_q[31] ? MIN_32 : MAX_32;
      end else begin
        w_shift_res = w_shl;
      end
    end
  end

  always_comb begin
    w_res     = 32'd0;
    w_res_ovf = 1'b0;
    case (s1_op_q)
      OP_L_MULT: begin
        w_res     = w_lm_sat;
        w_res_ovf = w_lm_ovf;
      end
      OP_MULT, OP_ADD: begin
        w_res     = w_narrow_res;
        w_res_ovf = w_narrow_ovf;
      end
      OP_L_MAC, OP_L_MSU: begin
        w_res     = w_wide_res;
        w_res_ovf = w_wide_ovf || w_lm_ovf;
      end
      OP_L_ADD: begin
        w_res     = w_wide_res;
        w_res_ovf = w_wide_ovf;
      end
      OP_L_SHR: begin
        w_res     = w_shift_res;
        w_res_ovf = w_shift_ovf;
      end
      default: begin
        w_res     = 32'd0;
        w_res_ovf = 1'b0;
      end
    endcase
  end

  always_comb begin
    ready_en_d = 1'b1;
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_c_d     = s1_c_q;
    s1_p_d     = s1_p_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_ovf_d   = s2_ovf_q;
    s2_tag_d   = s2_tag_q;
    if (w_advance) begin
      s1_valid_d = w_req_fire;
      if (w_req_fire) begin
        s1_op_d  = reqOp;
        s1_a_d   = reqA;
        s1_b_d   = reqB;
        s1_c_d   = reqC;
        s1_p_d   = {w_prod32[31], w_prod32};
        s1_tag_d = reqTag;
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = w_res;
        s2_ovf_d  = w_res_ovf;
        s2_tag_d  = s1_tag_q;
      end
    end
`ifdef BASIC_OP_OVF_STICKY_EN
    sticky_d = sticky_q;
    if (ovfClear) begin
      sticky_d = 1'b0;
    end
    if (s2_valid_q && rspReady && s2_ovf_q) begin
      sticky_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_L_MULT;
      s1_a_q     <= 16'd0;
      s1_b_q     <= 16'd0;
      s1_c_q     <= 32'd0;
      s1_p_q     <= 33'sd0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= 32'd0;
      s2_ovf_q   <= 1'b0;
      s2_tag_q   <= '0;
`ifdef BASIC_OP_OVF_STICKY_EN
      sticky_q   <= 1'b0;
`endif
    end else begin
      ready_en_q <= ready_en_d;
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_c_q     <= s1_c_d;
      s1_p_q     <= s1_p_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_ovf_q   <= s2_ovf_d;
      s2_tag_q   <= s2_tag_d;
`ifdef BASIC_OP_OVF_STICKY_EN
      sticky_q   <= sticky_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_basic_op_responder.sv
// +---------------------------------------------------------------------------+
// | tb_basic_op_responder : vector table + scoreboard bench for the responder.|
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_basic_op_responder;
  import g729_basic_op_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic        o;
  } vec_t;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] d;
    logic        o;
  } exp_t;

  localparam int NVEC = 26;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic [2:0]  reqOp;
  logic [15:0] reqA;
  logic [15:0] reqB;
  logic [31:0] reqC;
  logic [3:0]  reqTag;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspData;
  logic        rspOvf;
  logic [3:0]  rspTag;
`ifdef BASIC_OP_OVF_STICKY_EN
  logic        ovfSticky;
  logic        ovfClear;
`endif

  basic_op_responder #(.TAG_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .reqValid (reqValid),
    .reqReady (reqReady),
    .reqOp    (reqOp),
    .reqA     (reqA),
    .reqB     (reqB),
    .reqC     (reqC),
    .reqTag   (reqTag),
    .rspValid (rspValid),
    .rspReady (rspReady),
    .rspData  (rspData),
    .rspOvf   (rspOvf),
    .rspTag   (rspTag)
`ifdef BASIC_OP_OVF_STICKY_EN
    ,
    .ovfSticky(ovfSticky),
    .ovfClear (ovfClear)
`endif
  );

  always #5 clk = ~clk;

  vec_t        vecs [NVEC];
  exp_t        sb [$];
  exp_t        cur_exp;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_rsp = 0;
  logic        acc_last;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_tag;
  logic        toggle_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Called at a falling edge after inputs are set; evaluates the coming rising edge.
  task automatic step();
    exp_t e;
    #1;
    if (stall_prev) begin
      chk("stall_hold_valid", 32'(rspValid), 32'd1);
      chk("stall_hold_data", rspData, prev_data);
      chk("stall_hold_tag", 32'(rspTag), 32'(prev_tag));
    end
    acc_last = reqValid && reqReady;
    if (acc_last) sb.push_back(cur_exp);
    if (rspValid && rspReady) begin
      n_rsp++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rsp: actual tag=%h data=%h required=no response", rspTag, rspData);
      end else begin
        e = sb.pop_front();
        chk("rsp_data", rspData, e.d);
        chk("rsp_ovf", 32'(rspOvf), 32'(e.o));
        chk("rsp_tag", 32'(rspTag), 32'(e.tag));
      end
    end
    stall_prev = rspValid && !rspReady;
    prev_data  = rspData;
    prev_tag   = rspTag;
    @(negedge clk);
    if (toggle_mode) rspReady = ~rspReady;
  endtask

  task automatic send(input vec_t v, input logic [3:0] tag);
    int k;
    reqValid = 1'b1;
    reqOp    = v.op;
    reqA     = v.a;
    reqB     = v.b;
    reqC     = v.c;
    reqTag   = tag;
    cur_exp  = '{tag: tag, d: v.d, o: v.o};
    acc_last = 1'b0;
    k = 0;
    while (!acc_last && k < 50) begin
      step();
      k++;
    end
    if (!acc_last) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_accept_timeout: actual=not accepted required=accepted within 50 cycles");
    end
    reqValid = 1'b0;
  endtask

  task automatic drain();
    int k;
    reqValid = 1'b0;
    rspReady = 1'b1;
    k = 0;
    while ((sb.size() != 0 || rspValid) && k < 20) begin
      step();
      k++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=simulation still running required=finished");
    $fatal(1);
  end

  initial begin
    int base;
    vecs[0]  = '{OP_L_MULT, 16'h4000, 16'h4000, 32'h0,         32'h2000_0000, 1'b0};
    vecs[1]  = '{OP_L_MULT, 16'h8000, 16'h8000, 32'h0,         32'h7FFF_FFFF, 1'b1};
    vecs[2]  = '{OP_L_MULT, 16'hFFFF, 16'h0003, 32'h0,         32'hFFFF_FFFA, 1'b0};
    vecs[3]  = '{OP_MULT,   16'h8000, 16'h8000, 32'h0,         32'h0000_7FFF, 1'b1};
    vecs[4]  = '{OP_MULT,   16'h4000, 16'h4000, 32'h0,         32'h0000_2000, 1'b0};
    vecs[5]  = '{OP_MULT,   16'hC000, 16'h4000, 32'h0,         32'hFFFF_E000, 1'b0};
    vecs[6]  = '{OP_L_MAC,  16'h4000, 16'h4000, 32'h7FFF_FFF0, 32'h7FFF_FFFF, 1'b1};
    vecs[7]  = '{OP_L_MSU,  16'h4000, 16'h4000, 32'h8000_0010, 32'h8000_0000, 1'b1};
    vecs[8]  = '{OP_L_MAC,  16'h0002, 16'h0003, 32'h0000_0010, 32'h0000_001C, 1'b0};
    vecs[9]  = '{OP_L_MAC,  16'h8000, 16'h8000, 32'h0,         32'h7FFF_FFFF, 1'b1};
    vecs[10] = '{OP_ADD,    16'h7FFF, 16'h0001, 32'h0,         32'h0000_7FFF, 1'b1};
    vecs[11] = '{OP_ADD,    16'h8000, 16'hFFFF, 32'h0,         32'hFFFF_8000, 1'b1};
    vecs[12] = '{OP_ADD,    16'h1234, 16'h0011, 32'h0,         32'h0000_1245, 1'b0};
    vecs[13] = '{OP_ADD,    16'hFFFE, 16'h0001, 32'h0,         32'hFFFF_FFFF, 1'b0};
    vecs[14] = '{OP_L_SHR,  16'h0,    16'h0004, 32'h8000_0000, 32'hF800_0000, 1'b0};
    vecs[15] = '{OP_L_SHR,  16'h0,    16'h0028, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[16] = '{OP_L_SHR,  16'h0,    16'hFFFF, 32'h4000_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[17] = '{OP_L_SHR,  16'h0,    16'h0000, 32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[18] = '{OP_L_SHR,  16'h0,    16'hFFFC, 32'h0000_1234, 32'h0001_2340, 1'b0};
    vecs[19] = '{OP_L_SHR,  16'h0,    16'hFFD8, 32'hFFFF_0000, 32'h8000_0000, 1'b1};
    vecs[20] = '{OP_L_SHR,  16'h0,    16'h001F, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[21] = '{OP_L_ADD,  16'h0000, 16'h0001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1};
    vecs[22] = '{OP_L_ADD,  16'h0001, 16'h0002, 32'h0001_0000, 32'h0002_0002, 1'b0};
    vecs[23] = '{OP_L_ADD,  16'hFFFF, 16'hFFFF, 32'h8000_0000, 32'h8000_0000, 1'b1};
    vecs[24] = '{OP_RSVD,   16'h1234, 16'h5678, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[25] = '{OP_L_MSU,  16'h0001, 16'h0001, 32'h0,         32'hFFFF_FFFE, 1'b0};

    reset    = 1'b0;
    reqValid = 1'b0;
    reqOp    = 3'd0;
    reqA     = 16'd0;
    reqB     = 16'd0;
    reqC     = 32'd0;
    reqTag   = 4'd0;
    rspReady = 1'b1;
`ifdef BASIC_OP_OVF_STICKY_EN
    ovfClear = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_reqReady", 32'(reqReady), 32'd0);
    chk("reset_rspValid", 32'(rspValid), 32'd0);
    chk("reset_rspData", rspData, 32'd0);
    chk("reset_rspOvf", 32'(rspOvf), 32'd0);
    chk("reset_rspTag", 32'(rspTag), 32'd0);
`ifdef BASIC_OP_OVF_STICKY_EN
    chk("reset_ovfSticky", 32'(ovfSticky), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("ready_after_reset", 32'(reqReady), 32'd1);
    @(negedge clk);

    // Latency: response visible two cycles after the accepting cycle
    send(vecs[0], 4'hA);
    #1;
    chk("latency_cycle1_valid", 32'(rspValid), 32'd0);
    step();
    #1;
    chk("latency_cycle2_valid", 32'(rspValid), 32'd1);
    step();
    drain();

    // Table, back-to-back at full throughput
    for (int i = 0; i < NVEC; i++) send(vecs[i], 4'(i));
    drain();

    // Back-to-back eight with rspReady toggling 1,0,1,0...
    base = n_rsp;
    rspReady = 1'b1;
    toggle_mode = 1'b1;
    for (int i = 0; i < 8; i++) send(vecs[(i * 3) % NVEC], 4'(i + 8));
    toggle_mode = 1'b0;
    drain();
    chk("toggle_rsp_count", 32'(n_rsp - base), 32'd8);

    // Reset with two requests in flight
    rspReady = 1'b0;
    send(vecs[4], 4'h1);
    send(vecs[5], 4'h2);
    #1;
    chk("inflight_before_reset", 32'(rspValid), 32'd1);
    reset = 1'b0;
    #1;
    chk("reset_drops_rspValid", 32'(rspValid), 32'd0);
    chk("reset_drops_reqReady", 32'(reqReady), 32'd0);
    sb.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    rspReady = 1'b1;
    base = n_rsp;
    repeat (6) step();
    chk("no_stale_after_reset", 32'(n_rsp - base), 32'd0);

`ifdef BASIC_OP_OVF_STICKY_EN
    // Sticky overflow: set, clear, then clear colliding with a new overflow
    send(vecs[3], 4'h3);
    drain();
    #1;
    chk("sticky_set", 32'(ovfSticky), 32'd1);
    @(negedge clk);
    ovfClear = 1'b1;
    step();
    ovfClear = 1'b0;
    #1;
    chk("sticky_cleared", 32'(ovfSticky), 32'd0);
    @(negedge clk);
    rspReady = 1'b0;
    send(vecs[3], 4'h4);
    step();
    rspReady = 1'b1;
    ovfClear = 1'b1;
    step();
    ovfClear = 1'b0;
    #1;
    chk("sticky_set_wins", 32'(ovfSticky), 32'd1);
    @(negedge clk);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
